// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Runs one full-adder slice (two half-adder stages plus a carry flop) over
// WIDTH-bit operands, LSB first. Each operation takes WIDTH cycles in RUN,
// followed by a one-cycle Done pulse.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a Sub input. When Sub is set,
// the block computes A-B using ~B and a carry-in of 1.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             busy_q, done_q;

    logic             sub_sel;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, c_next;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub_i;
`else
    assign sub_sel = 1'b0;
`endif

    // One-bit slice: first half adder on the operand bits, second one folds in the carry.
    assign ha1_s  = a_q[0] ^ b_q[0];
    assign ha1_c  = a_q[0] & b_q[0];
    assign ha2_s  = ha1_s ^ c_q;
    assign ha2_c  = ha1_s & c_q;
    assign c_next = ha1_c | ha2_c;

    // Next-state logic: accept in IDLE/DONE, one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    // A subtract loads the inverted B with a carry-in of 1.
                    a_d     = a_i;
                    b_d     = sub_sel ? ~b_i : b_i;
                    c_d     = sub_sel;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d = {ha2_s, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                if (cnt_q == LAST_BIT) begin
                    // The counter stops at the last bit, so it never wraps.
                    carry_d = c_next;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. The status flags are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8), using directed vectors.
// A transaction-level model tracks when each result is due and what it must be.
// A compare process checks every cycle against that model, and the directed
// tasks check hand-computed literal results.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         sub;
    logic         busy, done, carry;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .carry_o (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Model phase: 0 = idle, 1..W = cycles after accept while running, W+1 = result cycle.
    int          m_phase;
    logic [W:0]  m_pend;
    logic [W-1:0] m_sum;
    logic        m_carry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_pend  <= '0;
            m_sum   <= '0;
            m_carry <= 1'b0;
        end else if (m_phase == 0 || m_phase == W + 1) begin
            if (start) begin
                m_phase <= 1;
`ifdef SERIAL_ADD_SUB_EN
                if (sub)
                    m_pend <= {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                else
                    m_pend <= {1'b0, a} + {1'b0, b};
`else
                m_pend <= {1'b0, a} + {1'b0, b};
`endif
            end else begin
                m_phase <= 0;
            end
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == W) begin
                m_sum   <= m_pend[W-1:0];
                m_carry <= m_pend[W];
            end
        end
    end

    // Check every cycle. Sum and Carry are compared except while the operands are still shifting.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_busy", 32'(busy), 32'((m_phase >= 1 && m_phase <= W) ? 1 : 0));
            check("model_done", 32'(done), 32'((m_phase == W + 1) ? 1 : 0));
            if (m_phase == 0 || m_phase == W + 1) begin
                check("model_sum", 32'(sum), 32'(m_sum));
                check("model_carry", 32'(carry), 32'(m_carry));
            end
        end
    end

    // Waits for Done with a cycle limit, then checks the literal result and the latency.
    task automatic wait_done(input string nm, input logic [W-1:0] es, input logic ec,
                             input int exp_lat);
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check({nm, "_timeout"}, 32'(done), 32'(1));
        end else begin
            check({nm, "_sum"}, 32'(sum), 32'(es));
            check({nm, "_carry"}, 32'(carry), 32'(ec));
            if (exp_lat >= 0) check({nm, "_latency"}, 32'(n), 32'(exp_lat));
        end
        $display("op %s: sum=0x%02h carry=%0d after %0d cycles", nm, sum, carry, n);
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic [W-1:0] es, input logic ec);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, es, ec, W);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_carry", 32'(carry), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));

        do_op("add_35_1c", 8'h35, 8'h1C, 1'b0, 8'h51, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Sum and Carry must hold while idle.
        repeat (4) @(negedge clk);
        check("hold_sum", 32'(sum), 32'(8'h00));
        check("hold_carry", 32'(carry), 32'(1));

        // A second Start while running is ignored. After that, Start is held in the Done cycle.
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 8'h30, 1'b0, -1);
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("back_to_back", 8'h03, 1'b0, W);
        @(negedge clk);
        check("single_done_idle", 32'(done), 32'(0));

        // Reset during the fourth RUN cycle clears all outputs at once.
        do_op("pre_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        a = 8'h35; b = 8'h1C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_carry", 32'(carry), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op("add_02_03", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub_10_03", 8'h10, 8'h03, 1'b1, 8'h0D, 1'b1);
        do_op("sub_03_10", 8'h03, 8'h10, 1'b1, 8'hF3, 1'b0);
        do_op("nosub_03_10", 8'h03, 8'h10, 1'b0, 8'h13, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit adder slice (two half-adder stages plus carry flop) over WIDTH-bit operands, LSB first. It trades area for latency in the ComputerArchitecture arithmetic labs. It accepts a Start request, latches both operands, runs one bit per clock, and returns a registered Sum/Carry with a one-cycle Done pulse. It sits between a requester (lab top level or a test sequencer) and the shared adder slice.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled on the rising edge of Clk in IDLE or DONE only.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; result valid.
- Sum  output  WIDTH  result register.
- Carry  output  1  carry-out of the MSB.
- Sub  input  1  only with SERIAL_ADD_SUB_EN; captured with A/B.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start=1 latches A and B into shift registers, clears the carry flop and the bit counter, and moves to RUN.
  - RUN: each cycle computes one bit:
    - s = a0 ^ b0 ^ c
    - c' = (a0 & b0) | (c & (a0 ^ b0))
    - s shifts into Sum from the MSB side; operand registers shift right.
    - The counter increments. When the counter reaches WIDTH-1, the FSM goes to DONE.
  - DONE: Done=1 for exactly one cycle; Carry takes the final c'. With Start=1, new operands are accepted and the FSM goes to RUN (back-to-back). Otherwise it goes to IDLE.
- Start in RUN is ignored. There is no queueing; the requester must wait for Done.
- Sum holds a partially shifted value during RUN and is only meaningful from Done until the next accepting edge. Sum and Carry hold indefinitely in IDLE.
- Arithmetic is modulo 2^WIDTH. Carry is the true carry-out. The counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Sum=0, Carry=0, counter=0, operand registers=0.
- Rst_n low at any time, including mid-RUN, immediately clears all state. The operation in flight is lost and no Done is produced.
- Accepting edge is edge E. RUN occupies cycles E+1..E+WIDTH (Busy=1). Done=1 in cycle E+WIDTH+1. Latency from Start to Done is WIDTH+1 cycles.
- Sum/Carry are stable and valid in the Done cycle.
- Back-to-back throughput is one result per WIDTH+1 cycles (Start held high in the Done cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Sub is a port and is latched on the accepting edge.
  - Sub=1 loads ~B into the B shift register and presets the carry flop to 1, giving A-B modulo 2^WIDTH.
  - Carry=1 means no borrow (A>=B unsigned).
  - Sub=0 behaves as add.
- SERIAL_ADD_SUB_EN undefined: no Sub port; add only; the carry flop always clears to 0 on accept.

## Test plan
- Reset: Rst_n=0 for 3 cycles, then release -> Busy=0, Done=0, Sum=0x00, Carry=0. Release Rst_n with Start=0 -> the FSM stays IDLE.
- Basic add, WIDTH=8: A=0x35, B=0x1C, Start one cycle -> Busy high 8 cycles; Done in cycle 9 after accept; Sum=0x51, Carry=0.
- Overflow: A=0xFF, B=0x01 -> Sum=0x00, Carry=1. A=0x80, B=0x80 -> Sum=0x00, Carry=1.
- Start ignored while busy: Start=1 with A=0x10, B=0x20, then Start=1 again 3 cycles later with A=0xAA -> single Done, Sum=0x30. Back-to-back Start in the Done cycle with A=0x01, B=0x02 -> next Done exactly 9 cycles later, Sum=0x03.
- Reset mid-op: assert Rst_n=0 in the 4th RUN cycle of 0x35+0x1C -> outputs zero at once, no Done pulse. The next add 0x02+0x03 -> Sum=0x05.
- With SERIAL_ADD_SUB_EN: Sub=1, A=0x10, B=0x03 -> Sum=0x0D, Carry=1. Sub=1, A=0x03, B=0x10 -> Sum=0xF3, Carry=0.
